// File: rtl/sd_cmd_pkg.sv
// Shared types and frame constants for the SD command-path sender.
// Frame layout: start bit, transmission bit, index, argument, CRC7, end bit.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRC_REQ,
        CRC_GAP,
        CRC_WAIT,
        LOAD,
        SHIFT,
        TAIL,
        DONE
    } sd_cmd_state_e;

    localparam int   SD_FRAME_W   = 48;
    localparam int   SD_CRC_IN_W  = 40;
    localparam logic SD_START_BIT = 1'b0;
    localparam logic SD_TX_BIT    = 1'b1;
    localparam logic SD_END_BIT   = 1'b1;

    function automatic logic [SD_CRC_IN_W-1:0] sd_crc_input(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        return {SD_START_BIT, SD_TX_BIT, idx, arg};
    endfunction

    // The CRC input already begins with the start and transmission bits.
    function automatic logic [SD_FRAME_W-1:0] sd_build_frame(
        input logic [SD_CRC_IN_W-1:0] crc_in,
        input logic [6:0]             crc
    );
        return {crc_in, crc, SD_END_BIT};
    endfunction

endpackage

// File: rtl/sd_cmd_shifter.sv
// 48-bit parallel-load, MSB-first shift register with a down-counting bit counter.
// empty goes high once bit 0 has been shifted out (and out of reset).
module sd_cmd_shifter
    import sd_cmd_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [SD_FRAME_W-1:0] load_data,
    output logic                  msb,
    output logic                  empty
);

    logic [SD_FRAME_W-1:0] sreg_q, sreg_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic                  empty_q, empty_d;

    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        empty_d   = empty_q;
        if (load) begin
            sreg_d    = load_data;
            bit_cnt_d = 6'(SD_FRAME_W - 1);
            empty_d   = 1'b0;
        end else if (shift_en && !empty_q) begin
            sreg_d = {sreg_q[SD_FRAME_W-2:0], 1'b0};
            // Counter parks at zero; empty marks that bit 0 has gone out.
            if (bit_cnt_q == 6'd0) begin
                empty_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q - 6'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            empty_q   <= 1'b1;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            empty_q   <= empty_d;
        end
    end

    assign msb   = sreg_q[SD_FRAME_W-1];
    assign empty = empty_q;

endmodule

// File: rtl/sd_cmd_sender.sv
// SD CMD-line sender: fetches CRC7 from the lookup engine, then shifts the 48-bit frame out.
// Optional CRC_TIMEOUT_EN macro aborts a CRC wait after TIMEOUT_CYC cycles with cmd_err.
//
//   state    | meaning
//   IDLE     | waiting for cmd_start
//   CRC_REQ  | crc_req high for one cycle
//   CRC_GAP  | dead cycle, previous command's crc_valid may still be high
//   CRC_WAIT | waiting for crc_valid
//   LOAD     | frame loaded into shifter, line not yet driven
//   SHIFT    | one frame bit per sd_clk_en tick
//   TAIL     | line held high with drive enabled for TAIL_TICKS ticks
//   DONE     | cmd_done (or cmd_err) pulse cycle, busy drops next cycle
module sd_cmd_sender
    import sd_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned TAIL_TICKS  = 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   cmd_start,
    input  logic [5:0]             cmd_index,
    input  logic [31:0]            cmd_arg,
    output logic                   cmd_busy,
    output logic                   cmd_done,
    output logic                   cmd_err,
    output logic [SD_CRC_IN_W-1:0] crc_indata,
    output logic                   crc_req,
    input  logic [6:0]             crc_data,
    input  logic                   crc_valid,
    input  logic                   sd_clk_en,
    output logic                   sd_cmd_out,
    output logic                   sd_cmd_oe
);

    sd_cmd_state_e          state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   req_q, req_d;
    logic [SD_CRC_IN_W-1:0] indata_q, indata_d;
    logic [6:0]             crc_q, crc_d;
    logic                   out_q, out_d;
    logic                   oe_q, oe_d;
    logic [7:0]             tail_cnt_q, tail_cnt_d;
    logic                   sh_load, sh_shift, sh_msb, sh_empty;

`ifdef CRC_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        req_d      = 1'b0;
        indata_d   = indata_q;
        crc_d      = crc_q;
        out_d      = out_q;
        oe_d       = oe_q;
        tail_cnt_d = tail_cnt_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
`ifdef CRC_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    indata_d = sd_crc_input(cmd_index, cmd_arg);
                    busy_d   = 1'b1;
                    req_d    = 1'b1;
                    state_d  = CRC_REQ;
                end
            end
            CRC_REQ: state_d = CRC_GAP;
            CRC_GAP: begin
`ifdef CRC_TIMEOUT_EN
                tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
`endif
                state_d = CRC_WAIT;
            end
            CRC_WAIT: begin
                if (crc_valid) begin
                    crc_d   = crc_data;
                    state_d = LOAD;
                end
`ifdef CRC_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            LOAD: begin
                sh_load = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sd_clk_en) begin
                    oe_d = 1'b1;
                    if (sh_empty) begin
                        out_d      = SD_END_BIT;
                        tail_cnt_d = 8'(TAIL_TICKS - 1);
                        state_d    = TAIL;
                    end else begin
                        out_d    = sh_msb;
                        sh_shift = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (sd_clk_en) begin
                    if (tail_cnt_q == 8'd0) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        tail_cnt_d = tail_cnt_q - 8'd1;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            indata_q   <= '0;
            crc_q      <= '0;
            out_q      <= 1'b1;
            oe_q       <= 1'b0;
            tail_cnt_q <= '0;
`ifdef CRC_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            req_q      <= req_d;
            indata_q   <= indata_d;
            crc_q      <= crc_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            tail_cnt_q <= tail_cnt_d;
`ifdef CRC_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    sd_cmd_shifter u_shifter (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (sh_load),
        .shift_en  (sh_shift),
        .load_data (sd_build_frame(indata_q, crc_q)),
        .msb       (sh_msb),
        .empty     (sh_empty)
    );

    assign cmd_busy   = busy_q;
    assign cmd_done   = done_q;
    assign cmd_err    = err_q;
    assign crc_req    = req_q;
    assign crc_indata = indata_q;
    assign sd_cmd_out = out_q;
    assign sd_cmd_oe  = oe_q;

endmodule

// File: doc/sd_cmd_sender.md
Name: sd_cmd_sender

Overview:
Sequencer for the SD command path. Accepts a command index and 32-bit argument, then drives the CRC7 table-lookup engine over its req/data handshake. It assembles the 48-bit SD command frame and shifts it MSB-first onto the CMD line at the SD clock-enable rate. It sits between the SD card controller FSM and the CRC7 engine, and owns the CMD line drive enable.

Parameters:
TIMEOUT_CYC, 64, max sys_clk cycles allowed in CRC_WAIT before abort (used only with CRC_TIMEOUT_EN)
TAIL_TICKS, 1, sd_clk_en ticks the line is held at 1 with drive enabled after the end bit

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
cmd_start  in  1  single-cycle request; accepted only in IDLE
cmd_index  in  6  command index, latched on acceptance
cmd_arg  in  32  command argument, latched on acceptance
cmd_busy  out  1  high from acceptance until the cycle after cmd_done/cmd_err
cmd_done  out  1  one-cycle pulse when the frame and tail are complete
cmd_err  out  1  one-cycle pulse on CRC timeout (only with CRC_TIMEOUT_EN)
crc_indata  out  40  {2'b01, cmd_index, cmd_arg} to the CRC7 engine
crc_req  out  1  one-cycle request to the CRC7 engine
crc_data  in  7  CRC7 result
crc_valid  in  1  CRC7 result valid; level, stays high until the engine's next request
sd_clk_en  in  1  one-cycle tick per SD clock period, from the clock divider
sd_cmd_out  out  1  CMD line data
sd_cmd_oe  out  1  CMD line drive enable

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame):
  - state=IDLE; cmd_busy=0, cmd_done=0, cmd_err=0, crc_req=0.
  - crc_indata=0, sd_cmd_out=1, sd_cmd_oe=0; shift register and counters cleared.
- IDLE:
  - On cmd_start=1: latch index/arg, drive crc_indata, set cmd_busy=1, go to CRC_REQ.
  - cmd_start in any other state is ignored; no queueing.
- CRC_REQ: crc_req=1 for exactly one cycle, then go to CRC_GAP.
- CRC_GAP:
  - One dead cycle. crc_valid is not sampled here, because the engine's valid from the previous command is still high on the request edge.
  - Go to CRC_WAIT.
- CRC_WAIT:
  - On crc_valid=1, register crc_data, then go to LOAD.
  - crc_indata is held stable throughout the wait.
- LOAD:
  - shift_reg[47:0] = {1'b0, 1'b1, index, arg, crc, 1'b1}; bit_cnt=47. Go to SHIFT.
  - sd_cmd_oe is still 0 here.
- SHIFT: on each sd_clk_en=1:
  - sd_cmd_oe=1, sd_cmd_out=shift_reg[47]; shift left, bit_cnt decrements.
  - After bit 0 has been driven, the next tick moves to TAIL.
  - Without a tick, outputs hold.
- TAIL:
  - Drive sd_cmd_out=1, sd_cmd_oe=1 for TAIL_TICKS ticks.
  - Then sd_cmd_oe=0 and go to DONE.
- DONE: cmd_done=1 for one cycle, cmd_busy=0 next cycle, return to IDLE.
- Ticks outside SHIFT/TAIL are ignored. A tick coinciding with the LOAD cycle is not used; the first bit goes out on the first tick after LOAD.
- Latency: command accepted to first bit = 3 + CRC engine latency (about 17 cycles) + 1 + wait for next tick. Frame = 48 ticks + TAIL_TICKS.
- Widths: crc_indata bit 39 = 0, bit 38 = 1. All counters are unsigned; bit_cnt does not wrap below 0.

Optional Feature:
CRC_TIMEOUT_EN:
- Defined: a counter runs in CRC_WAIT. At TIMEOUT_CYC cycles without crc_valid, pulse cmd_err=1 for one cycle, never assert sd_cmd_oe, return to IDLE with cmd_busy=0 on the next cycle.
- Undefined: CRC_WAIT waits indefinitely; cmd_err is tied to 0.

Decomposition:
- Package sd_cmd_pkg holds:
  - state encoding: IDLE, CRC_REQ, CRC_GAP, CRC_WAIT, LOAD, SHIFT, TAIL, DONE
  - constants: SD_FRAME_W=48, SD_CRC_IN_W=40, SD_START_BIT=0, SD_TX_BIT=1, SD_END_BIT=1
- One sub-module: sd_cmd_shifter, a 48-bit parallel-load shift register with tick enable and a bit counter.

Test Plan:
- CMD0, arg 0x00000000, with the real CRC7 engine and table: crc=0x4A, line carries 0x400000000095, then 1 tail bit high, cmd_done one pulse.
- CMD17, arg 0x00000000: crc=0x2A, frame 0x510000000055. CMD8, arg 0x000001AA: crc=0x43, frame 0x48000001AA87.
- Stale valid: stub holds crc_valid=1 from the previous command with data 0x7F and delays the new result 20 cycles → frame uses the new CRC, not 0x7F.
- cmd_start pulsed during SHIFT with a different index → ignored; the current frame completes unchanged; exactly one cmd_done.
- sys_rst_n asserted at bit 20 of the shift → sd_cmd_oe=0 and sd_cmd_out=1 immediately; after release cmd_busy=0 and a new CMD0 sends correctly.
- CRC_TIMEOUT_EN defined, TIMEOUT_CYC=64, stub never asserts crc_valid → cmd_err pulse 64 cycles after entering CRC_WAIT, sd_cmd_oe never high.
